// File: rtl/fp_sign_pkg.sv
// Shared definitions for the IEEE-754 sign-manipulation unit.
//   - Operation mode encodings carried on input_mode.
//   - Result flag layout and bit indices for output_flags.
//   - fp_class(): classifies an exponent/mantissa pair as NaN, Inf or zero.
package fp_sign_pkg;

  // Operation modes
  localparam logic [1:0] MODE_NEG      = 2'b00;
  localparam logic [1:0] MODE_ABS      = 2'b01;
  localparam logic [1:0] MODE_NABS     = 2'b10;
  localparam logic [1:0] MODE_COPYSIGN = 2'b11;

  // Flag vector layout: {is_nan, is_inf, is_zero, sign_changed}
  localparam int unsigned FLAG_W            = 4;
  localparam int unsigned FLAG_NAN          = 3;
  localparam int unsigned FLAG_INF          = 2;
  localparam int unsigned FLAG_ZERO         = 1;
  localparam int unsigned FLAG_SIGN_CHANGED = 0;

  // Widest fields fp_class accepts (binary128); callers zero-extend narrower fields.
  localparam int unsigned EXP_MAX_W  = 15;
  localparam int unsigned MANT_MAX_W = 112;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic sign_changed;
  } fp_flags_t;

  // Classify a value. exp_w gives the real exponent width so the all-ones test
  // ignores the zero-extension bits. sign_changed is left clear for the caller.
  function automatic fp_flags_t fp_class(input logic [EXP_MAX_W-1:0]  exp,
                                         input logic [MANT_MAX_W-1:0] mant,
                                         input int unsigned           exp_w);
    logic      exp_ones;
    logic      exp_zero;
    logic      mant_zero;
    fp_flags_t f;
    exp_ones = 1'b1;
    for (int unsigned i = 0; i < EXP_MAX_W; i++) begin
      if ((i < exp_w) && !exp[i]) exp_ones = 1'b0;
    end
    exp_zero       = (exp == '0);
    mant_zero      = (mant == '0);
    f.is_nan       = exp_ones & ~mant_zero;
    f.is_inf       = exp_ones & mant_zero;
    f.is_zero      = exp_zero & mant_zero;
    f.sign_changed = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/fp_sign_unit_stage.sv
// One elastic pipeline register holding {valid, data}.
//   in_stb/in_ack   : upstream handshake, transfer when both high
//   in_data         : payload captured on transfer
//   out_stb/out_ack : downstream handshake, out_stb is the valid bit
//   out_data        : registered payload, held while out_stb & ~out_ack
// in_ack is combinational (empty or draining) so a chain of these stages
// runs at one item per cycle with no bubbles.
module fp_pipe_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_stb,
  output logic          in_ack,
  input  logic [DW-1:0] in_data,
  output logic          out_stb,
  input  logic          out_ack,
  output logic [DW-1:0] out_data
);

  // Can load when empty or when the current item leaves this cycle.
  assign in_ack = ~out_stb | out_ack;

  // Valid/data register; data only changes on a real transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_stb  <= 1'b0;
      out_data <= '0;
    end else if (in_ack) begin
      out_stb <= in_stb;
      if (in_stb) out_data <= in_data;
    end
  end

endmodule

// File: rtl/fp_sign_unit.sv
// Pipelined IEEE-754 sign-manipulation unit (NEG / ABS / NABS / COPYSIGN)
// for any binary format, with elastic stb/ack handshakes on both sides.
//   clk, rst      : clock, synchronous active-high reset
//   input_a       : operand whose magnitude is kept
//   input_b       : sign source for COPYSIGN
//   input_mode    : 00 NEG, 01 ABS, 10 NABS, 11 COPYSIGN
//   input_stb/ack : input handshake
//   output_z      : result
//   output_flags  : {is_nan, is_inf, is_zero, sign_changed} of the result
//   output_z_stb/ack : output handshake
// LATENCY (1..4) register stages sit between the combinational sign logic
// and the output; EXP_W must not exceed 15 and MANT_W must not exceed 112.
module fp_sign_unit
  import fp_sign_pkg::*;
#(
  parameter int unsigned EXP_W   = 11,
  parameter int unsigned MANT_W  = 52,
  parameter int unsigned LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [EXP_W+MANT_W:0]     input_a,
  input  logic [EXP_W+MANT_W:0]     input_b,
  input  logic [1:0]                input_mode,
  input  logic                      input_stb,
  output logic                      input_ack,
  output logic [EXP_W+MANT_W:0]     output_z,
  output logic [FLAG_W-1:0]         output_flags,
  output logic                      output_z_stb,
  input  logic                      output_z_ack
);

  localparam int unsigned W  = 1 + EXP_W + MANT_W;
  localparam int unsigned DW = W + FLAG_W;

  logic          in_ready;
  logic          sign_z_c;
  logic [W-1:0]  z_c;
  fp_flags_t     flags_c;
  logic [DW-1:0] head_data_c;
  logic          unused_b_low;

  // Only B's sign bit matters; the rest of B is intentionally ignored.
  assign unused_b_low = ^input_b[W-2:0];

  // Holds input_ack low through reset and for the first edge after it.
  always_ff @(posedge clk) begin
    if (rst) in_ready <= 1'b0;
    else     in_ready <= 1'b1;
  end

  // Result sign select; magnitude bits always pass straight from A.
  always_comb begin
    sign_z_c = ~input_a[W-1];
    case (input_mode)
      MODE_NEG:      sign_z_c = ~input_a[W-1];
      MODE_ABS:      sign_z_c = 1'b0;
      MODE_NABS:     sign_z_c = 1'b1;
      MODE_COPYSIGN: sign_z_c = input_b[W-1];
      default:       sign_z_c = ~input_a[W-1];
    endcase
  end

  assign z_c = {sign_z_c, input_a[W-2:0]};

  // Classify the result; sign_changed compares against the original A sign.
  always_comb begin
    flags_c = fp_class(EXP_MAX_W'(z_c[W-2 -: EXP_W]),
                       MANT_MAX_W'(z_c[MANT_W-1:0]),
                       EXP_W);
    flags_c.sign_changed = sign_z_c ^ input_a[W-1];
  end

  assign head_data_c = {z_c, flags_c};

  // Stage chain: each stage takes its input from the previous one and its
  // drain signal from the next one (or the output handshake for the last).
  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    logic          in_stb;
    logic          in_ack;
    logic [DW-1:0] in_data;
    logic          out_stb;
    logic          out_ack;
    logic [DW-1:0] out_data;

    if (i == 0) begin : g_head
      assign in_stb  = input_stb & in_ready;
      assign in_data = head_data_c;
    end else begin : g_link
      assign in_stb  = g_stage[i-1].out_stb;
      assign in_data = g_stage[i-1].out_data;
    end

    if (i == LATENCY - 1) begin : g_tail
      assign out_ack = output_z_ack;
    end else begin : g_mid
      assign out_ack = g_stage[i+1].in_ack;
    end

    fp_pipe_stage #(
      .DW (DW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_stb   (in_stb),
      .in_ack   (in_ack),
      .in_data  (in_data),
      .out_stb  (out_stb),
      .out_ack  (out_ack),
      .out_data (out_data)
    );
  end

  assign input_ack    = g_stage[0].in_ack & in_ready;
  assign output_z_stb = g_stage[LATENCY-1].out_stb;
  assign output_z     = g_stage[LATENCY-1].out_data[DW-1 -: W];
  assign output_flags = g_stage[LATENCY-1].out_data[FLAG_W-1:0];

endmodule
